// File: rtl/aes_pkg.sv
// Shared AES datapath widths and the serializer control state type.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_FLAGGED_W = 129;
  localparam int AES_VALID_BIT = 128;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/block_fifo.sv
// Circular block buffer: head is visible the cycle after its push, no bypass.
// A push while full is accepted only alongside a pop; otherwise it is ignored here.
module block_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[head_ptr];

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PW'(1);
      if (pop_ok)  head_ptr <= head_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_out_serializer.sv
// Buffers flagged 128-bit ciphertext blocks and emits them MSW-first as WORD_W words;
// first word valid the cycle after the push, holds under out_ready=0, drops blocks when full.
module cipher_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AES_FLAGGED_W-1:0]   enRound,
  input  logic                       flush,
  output logic [WORD_W-1:0]          out_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int NWORDS = AES_BLOCK_W / WORD_W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  logic [AES_BLOCK_W-1:0] head;
  logic                   empty;
  logic                   blk_vld;
  logic                   xfer;
  logic                   pop;
  logic                   push;
  logic [IW-1:0]          widx;
  ser_state_e             state;

  assign blk_vld   = enRound[AES_VALID_BIT];
  assign out_valid = ~empty;
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (widx == LAST_IDX);
  assign push      = blk_vld & (~full | pop);
  assign out_last  = (state == ST_STREAM) & (widx == LAST_IDX);

  block_fifo #(
    .W     (AES_BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (enRound[AES_BLOCK_W-1:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= ST_EMPTY;
      widx     <= '0;
      overflow <= 1'b0;
    end else begin
      if (blk_vld && full && !pop) overflow <= 1'b1;
      if (xfer) widx <= (widx == LAST_IDX) ? '0 : widx + IW'(1);
      case (state)
        ST_EMPTY:  if (push) state <= ST_STREAM;
        ST_STREAM: if (pop && !push && count == CW'(1)) state <= ST_EMPTY;
        default:   state <= ST_EMPTY;
      endcase
    end
  end

  // Word 0 is the top slice so byte 0 of the block leaves first.
  always_comb begin
    out_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (out_valid && widx == IW'(k))
        out_word = head[AES_BLOCK_W-1-k*WORD_W -: WORD_W];
    end
  end

endmodule

// File: tb/tb_cipher_out_serializer.sv
// Directed bench for cipher_out_serializer at DEPTH=4, WORD_W=32.
module tb_cipher_out_serializer;

  logic         clk;
  logic         rst;
  logic [128:0] enRound;
  logic         flush;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         full;
  logic [2:0]   count;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  cipher_out_serializer #(.DEPTH(4), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enRound   (enRound),
    .flush     (flush),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Block i carries words c0de_ii0k so order and identity are visible per word.
  function automatic logic [127:0] blk(input int i);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[127-k*32 -: 32] = 32'hc0de0000 | (32'(i) << 8) | 32'(k);
    return r;
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] b, input int k);
    return b[127-k*32 -: 32];
  endfunction

  // Expect block b to stream out with out_ready held high, then advance past it.
  task automatic drain_block(input string tag, input logic [127:0] b);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
      chk({tag, "_word"},  128'(out_word),  128'(wd(b, k)));
      chk({tag, "_last"},  128'(out_last),  128'(k == 3));
      step();
    end
  endtask

  logic [127:0] b0;
  logic [127:0] b1;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; enRound = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_last",  128'(out_last),  128'(0));
    chk("rst_full",  128'(full),      128'(0));
    chk("rst_word",  128'(out_word),  128'(0));
    chk("rst_count", 128'(count),     128'(0));
    chk("rst_ovf",   128'(overflow),  128'(0));

    // Unflagged data must never enter the buffer.
    enRound = {1'b0, 128'hdeadbeef_01234567_89abcdef_feedface};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("novld_count", 128'(count),     128'(0));
      chk("novld_valid", 128'(out_valid), 128'(0));
    end

    // Single FIPS-197 ciphertext block.
    enRound = {1'b1, 128'h3925841d02dc09fbdc118597196a0b32};
    chk("nobypass_valid", 128'(out_valid), 128'(0));
    step();
    enRound = '0;
    chk("fips_w0",    128'(out_word), 128'(32'h3925841d));
    chk("fips_l0",    128'(out_last), 128'(0));
    step();
    chk("fips_w1",    128'(out_word), 128'(32'h02dc09fb));
    chk("fips_l1",    128'(out_last), 128'(0));
    step();
    chk("fips_w2",    128'(out_word), 128'(32'hdc118597));
    chk("fips_l2",    128'(out_last), 128'(0));
    step();
    chk("fips_w3",    128'(out_word), 128'(32'h196a0b32));
    chk("fips_l3",    128'(out_last), 128'(1));
    step();
    chk("fips_end_valid", 128'(out_valid), 128'(0));
    chk("fips_end_count", 128'(count),     128'(0));

    // Backpressure: each word must hold across two stalled cycles.
    b1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    out_ready = 1'b0;
    enRound = {1'b1, b1};
    step();
    enRound = '0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_word",  128'(out_word), 128'(wd(b1, k)));
      step();
      chk("bp_hold1", 128'(out_word), 128'(wd(b1, k)));
      chk("bp_lasth", 128'(out_last), 128'(k == 3));
      step();
      chk("bp_hold2", 128'(out_word), 128'(wd(b1, k)));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("bp_end_valid", 128'(out_valid), 128'(0));

    // Fill: five blocks into a four-deep buffer with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      enRound = {1'b1, blk(i)};
      step();
      if (i == 3) begin
        chk("fill_count4", 128'(count),    128'(4));
        chk("fill_full4",  128'(full),     128'(1));
        chk("fill_ovf4",   128'(overflow), 128'(0));
      end
    end
    enRound = '0;
    chk("fill_count5", 128'(count),    128'(4));
    chk("fill_ovf5",   128'(overflow), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drain_block("fill_drain", blk(i));
    chk("fill_end_valid", 128'(out_valid), 128'(0));
    chk("ovf_sticky",     128'(overflow),  128'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf", 128'(overflow), 128'(0));

    // Full with a pop on the same edge as a new push.
    out_ready = 1'b0;
    for (int i = 8; i < 12; i++) begin
      enRound = {1'b1, blk(i)};
      step();
    end
    enRound = '0;
    chk("fp_full", 128'(full), 128'(1));
    out_ready = 1'b1;
    step(); step(); step();
    chk("fp_last",  128'(out_last), 128'(1));
    enRound = {1'b1, blk(12)};
    step();
    enRound = '0;
    chk("fp_count", 128'(count),    128'(4));
    chk("fp_ovf",   128'(overflow), 128'(0));
    for (int i = 9; i < 13; i++) drain_block("fp_drain", blk(i));
    chk("fp_end_valid", 128'(out_valid), 128'(0));

    // Reset in the middle of a block discards the remainder.
    b0 = blk(20);
    enRound = {1'b1, b0};
    step();
    enRound = '0;
    step(); step();
    chk("mid_word2", 128'(out_word), 128'(wd(b0, 2)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_count", 128'(count),     128'(0));
    chk("mid_rst_word",  128'(out_word),  128'(0));
    enRound = {1'b1, blk(21)};
    step();
    enRound = '0;
    drain_block("mid_next", blk(21));
    chk("mid_end_valid", 128'(out_valid), 128'(0));

    // Flush wins over a concurrent push.
    out_ready = 1'b0;
    enRound = {1'b1, blk(22)};
    step();
    enRound = {1'b1, blk(23)};
    flush = 1'b1;
    step();
    flush = 1'b0;
    enRound = '0;
    chk("flush_count", 128'(count),     128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    step();
    chk("flush_stay",  128'(count),     128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cipher_out_serializer.md
CIPHER_OUT_SERIALIZER -- requirements
Module: cipher_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of 128-bit ciphertext blocks buffered (power of two, >=2).
REQ-002 SHALL have parameter WORD_W, default 32, meaning output word width; 128/WORD_W words per block (NWORDS=4 at default).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enRound  input  129  final-round output; [128]=block valid flag, [127:0]=ciphertext.
REQ-006 SHALL have port flush  input  1  synchronous clear of buffered blocks and word position.
REQ-007 SHALL have port out_word  output  WORD_W  current ciphertext word.
REQ-008 SHALL have port out_valid  output  1  out_word holds a valid word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_word this cycle.
REQ-010 SHALL have port out_last  output  1  out_word is the final word of its block.
REQ-011 SHALL have port full  output  1  DEPTH blocks buffered.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of buffered blocks.
REQ-013 SHALL have port overflow  output  1  sticky: a valid block was dropped.

Function
REQ-014 Push SHALL occur on a clock edge when enRound[128]=1 and (full=0 or a pop occurs in that same cycle); enRound[127:0] is stored at tail.
REQ-015 Transfer SHALL occur when out_valid=1 and out_ready=1; word index advances 0..NWORDS-1.
REQ-016 Pop SHALL occur on the transfer of word NWORDS-1; word index wraps to 0 and the next block becomes head.
REQ-017 Word order SHALL be most-significant first: word k = head[127-k*WORD_W -: WORD_W] (FIPS-197 byte 0 first).
REQ-018 out_valid SHALL equal (count!=0); out_word and out_last SHALL be driven combinationally from head entry and word index, and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 out_last SHALL be 1 exactly when out_valid=1 and word index = NWORDS-1.
REQ-020 Latency: block pushed on edge N SHALL appear with out_valid=1 in cycle after edge N when buffer was empty; no bypass in the push cycle.
REQ-021 Control SHALL use two states: EMPTY (count=0) and STREAM (count>0); EMPTY->STREAM on push; STREAM->EMPTY on pop with count=1 and no push; otherwise hold.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; at full, this push SHALL be accepted.
REQ-023 Push attempt while full with no pop SHALL drop the block, leave buffer intact, and set overflow=1 on that edge.
REQ-024 overflow SHALL remain 1 until rst or flush.
REQ-025 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-026 flush SHALL, on its edge, set count=0, pointers=0, word index=0, overflow=0, and ignore any concurrent push; flush takes priority over push/pop.

Reset
REQ-027 rst=1 on an edge SHALL set count=0, head/tail=0, word index=0, overflow=0, state=EMPTY; resulting outputs: out_valid=0, out_last=0, full=0, out_word=0 (storage contents irrelevant but out_word SHALL be masked to 0 when out_valid=0).
REQ-028 rst SHALL take priority over flush, push and pop, including mid-block (partially sent block discarded).

Structure
REQ-029 Shared package aes_pkg SHALL hold AES_BLOCK_W=128, AES_FLAGGED_W=129, AES_VALID_BIT=128 and the state enum typedef.
REQ-030 Storage and pointers SHALL be one sub-module block_fifo (width 128, depth DEPTH, push/pop/full/empty/count); serializer control and word index stay in the top.

Verification
REQ-031 Single block: enRound={1'b1,128'h3925841d02dc09fbdc118597196a0b32}, out_ready=1 -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles, out_last only on 4th, then out_valid=0.
REQ-032 Backpressure: out_ready toggled 1,0,0,1,... -> each word held stable during stalls, no word duplicated or skipped.
REQ-033 Fill: 5 valid blocks back-to-back, out_ready=0 -> count=4, full=1 after 4th, 5th dropped, overflow=1; release drains first 4 blocks in order.
REQ-034 Full with pop: full=1, out_ready=1 on last word while new block presented -> count stays 4, overflow stays 0, new block emerges last.
REQ-035 Reset mid-block: rst=1 after 2 words sent -> next cycle out_valid=0, count=0; next pushed block starts at word 0.
REQ-036 enRound[128]=0 with nonzero data for 10 cycles -> count stays 0, out_valid stays 0.
